branch_predict_unit: RTL and testbench

Parametrised successor to the execute-stage branch decision logic. It combines a direct-mapped branch history table of 2-bit saturating counters, which predicts conditional branches at fetch, with execute-stage resolution of all branches and jumps from the ALU flags. On a misprediction it issues a registered one-cycle redirect/flush to fetch, and it keeps a saturating mispredict counter. It sits between the fetch PC mux and the execute stage.

---
 rtl/branch_pkg.sv | 21 ++
 rtl/bht_table.sv | 37 +++
 rtl/branch_predict_unit.sv | 98 +++++++++
 tb/tb_branch_predict_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: opcodes, 2-bit counter states and decode helpers for the branch predict unit
package branch_pkg;
    localparam logic [4:0] BEQZ = 5'b01100;
    localparam logic [4:0] BNEZ = 5'b01101;
    localparam logic [4:0] BLTZ = 5'b01110;
    localparam logic [4:0] BGEZ = 5'b01111;
    localparam logic [4:0] J    = 5'b00100;
    localparam logic [4:0] JR   = 5'b00101;
    localparam logic [4:0] JAL  = 5'b00110;
    localparam logic [4:0] JALR = 5'b00111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // All four conditional branches share the 011xx opcode prefix.
    function automatic logic is_cond_branch(input logic [4:0] opcode);
        return opcode[4:2] == 3'b011;
    endfunction
endpackage

// File: rtl/bht_table.sv
// bht_table: direct-mapped table of 2-bit saturating counters
//   clk, rst    : clock, synchronous active-high reset (all entries -> INIT_CTR)
//   rd_idx_i    : fetch read index; rd_ctr_o is the counter, asynchronous read
//   we_i        : update enable; wr_idx_i selects the entry, taken_i the direction
module bht_table
    import branch_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] INIT_CTR = 2'b01,
    localparam int        IDX      = $clog2(ENTRIES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [IDX-1:0] rd_idx_i,
    output logic [1:0]     rd_ctr_o,
    input  logic           we_i,
    input  logic [IDX-1:0] wr_idx_i,
    input  logic           taken_i
);
    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] cur;
    logic [1:0] nxt;

    always_comb begin
        rd_ctr_o = ctr_q[rd_idx_i];
        cur      = ctr_q[wr_idx_i];
        nxt      = taken_i ? (cur == ST ? ST : cur + 2'd1) : (cur == SNT ? SNT : cur - 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_CTR;
        end else if (we_i) begin
            ctr_q[wr_idx_i] <= nxt;
        end
    end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: fetch-time branch prediction and execute-time resolution with redirect
//   clk, rst            : clock, synchronous active-high reset
//   f_valid/f_pc/f_opcode -> p_taken : combinational fetch prediction
//   x_valid, x_pc, x_opcode, x_pred_taken, x_pos/x_neg/x_zero,
//   x_target, x_reg_target, x_pc_plus2 : execute-stage branch/jump inputs
//   link_en             : combinational, write PC+2 to R7 for JAL/JALR
//   redirect, redirect_pc : registered one-cycle flush and corrected fetch PC
//   mispredict_cnt      : saturating count of redirects
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int         PC_W     = 16,
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_valid,
    input  logic [PC_W-1:0] f_pc,
    input  logic [4:0]      f_opcode,
    output logic            p_taken,
    input  logic            x_valid,
    input  logic [PC_W-1:0] x_pc,
    input  logic [4:0]      x_opcode,
    input  logic            x_pred_taken,
    input  logic            x_pos,
    input  logic            x_neg,
    input  logic            x_zero,
    input  logic [PC_W-1:0] x_target,
    input  logic [PC_W-1:0] x_reg_target,
    input  logic [PC_W-1:0] x_pc_plus2,
    output logic            link_en,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     mispredict_cnt
);
    localparam int IDX = $clog2(ENTRIES);

    logic [1:0]      f_ctr;
    logic            x_act;
    logic            x_cond;
    logic            x_jr;
    logic            x_taken;
    logic            redirect_d;
    logic            redirect_q;
    logic [PC_W-1:0] redirect_pc_d;
    logic [PC_W-1:0] redirect_pc_q;
    logic [15:0]     cnt_d;
    logic [15:0]     cnt_q;
    logic            unused_ok;

    // PC bit 0 and bits above the index never address the table.
    assign unused_ok = ^{f_pc[0], f_pc[PC_W-1:IDX+1], x_pc[0], x_pc[PC_W-1:IDX+1]};

    bht_table #(
        .ENTRIES (ENTRIES),
        .INIT_CTR(INIT_CTR)
    ) u_bht (
        .clk     (clk),
        .rst     (rst),
        .rd_idx_i(f_pc[IDX:1]),
        .rd_ctr_o(f_ctr),
        .we_i    (x_act & x_cond),
        .wr_idx_i(x_pc[IDX:1]),
        .taken_i (x_taken)
    );

    always_comb begin
        p_taken       = f_valid & (is_cond_branch(f_opcode) ? f_ctr[1] : (f_opcode == J || f_opcode == JAL));
        link_en       = x_valid & (x_opcode == JAL || x_opcode == JALR);
        x_cond        = is_cond_branch(x_opcode);
        x_jr          = x_opcode == JR || x_opcode == JALR;
        // Low opcode bits select BEQZ/BNEZ/BLTZ/BGEZ conditions.
        x_taken       = x_opcode[1] ? (x_opcode[0] ? x_pos | x_zero : x_neg)
                                    : (x_opcode[0] ? x_pos | x_neg  : x_zero);
        // The instruction in execute during a redirect cycle is wrong-path.
        x_act         = x_valid & ~redirect_q;
        redirect_d    = x_act & (x_jr | (x_cond & (x_taken != x_pred_taken)));
        redirect_pc_d = x_jr ? x_reg_target : x_taken ? x_target : x_pc_plus2;
        cnt_d         = cnt_q + {15'd0, redirect_d & ~&cnt_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            redirect_q <= redirect_d;
            cnt_q      <= cnt_d;
            if (redirect_d) redirect_pc_q <= redirect_pc_d;
        end
    end

    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: randomized + directed scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;
    typedef struct {
        int          cyc;
        logic [15:0] pc;
        logic [15:0] cnt;
    } rev_t;
    typedef struct {
        logic p;
        logic l;
    } comb_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        f_valid = 0;
    logic [15:0] f_pc = 0;
    logic [4:0]  f_opcode = 0;
    logic        p_taken;
    logic        x_valid = 0;
    logic [15:0] x_pc = 0;
    logic [4:0]  x_opcode = 0;
    logic        x_pred_taken = 0;
    logic        x_pos = 0, x_neg = 0, x_zero = 0;
    logic [15:0] x_target = 0, x_reg_target = 0, x_pc_plus2 = 0;
    logic        link_en;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mispredict_cnt;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   m_ctr [16];
    bit   m_redir = 0;
    int   m_cnt = 0;
    rev_t rq[$];
    comb_t cq[$];

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc), .f_opcode(f_opcode),
        .p_taken(p_taken), .x_valid(x_valid), .x_pc(x_pc), .x_opcode(x_opcode),
        .x_pred_taken(x_pred_taken), .x_pos(x_pos), .x_neg(x_neg), .x_zero(x_zero),
        .x_target(x_target), .x_reg_target(x_reg_target), .x_pc_plus2(x_pc_plus2),
        .link_en(link_en), .redirect(redirect), .redirect_pc(redirect_pc),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int idx(input logic [15:0] pc);
        return (int'(pc) / 2) % 16;
    endfunction

    function automatic bit is_cond(input logic [4:0] op);
        return op >= 5'd12 && op <= 5'd15;
    endfunction

    function automatic bit model_pred(input logic [15:0] pc, input logic [4:0] op);
        if (is_cond(op)) return m_ctr[idx(pc)] >= 2;
        return op == 5'd4 || op == 5'd6;
    endfunction

    // Applies one cycle of stimulus and advances the reference model.
    task automatic drive(input bit r, input bit fv, input logic [15:0] fpc, input logic [4:0] fop,
                         input bit xv, input logic [15:0] xpc, input logic [4:0] xop, input bit xp,
                         input logic [2:0] fl, input logic [15:0] rt);
        bit          t;
        bit          nr;
        logic [15:0] npc;
        comb_t       c;
        @(posedge clk);
        #1;
        rst = r; f_valid = fv; f_pc = fpc; f_opcode = fop;
        x_valid = xv; x_pc = xpc; x_opcode = xop; x_pred_taken = xp;
        {x_pos, x_neg, x_zero} = fl;
        x_target = 16'($urandom); x_reg_target = rt; x_pc_plus2 = xpc + 16'd2;
        c.p = fv && model_pred(fpc, fop);
        c.l = xv && (xop == 5'd6 || xop == 5'd7);
        cq.push_back(c);
        if (r) begin
            m_redir = 0;
            m_cnt = 0;
            foreach (m_ctr[i]) m_ctr[i] = 1;
        end else begin
            nr = 0;
            npc = 0;
            if (xv && !m_redir) begin
                if (is_cond(xop)) begin
                    case (xop)
                        5'd12:   t = fl[0];
                        5'd13:   t = fl[2] | fl[1];
                        5'd14:   t = fl[1];
                        default: t = fl[2] | fl[0];
                    endcase
                    m_ctr[idx(xpc)] = t ? (m_ctr[idx(xpc)] == 3 ? 3 : m_ctr[idx(xpc)] + 1)
                                        : (m_ctr[idx(xpc)] == 0 ? 0 : m_ctr[idx(xpc)] - 1);
                    if (t != xp) begin
                        nr = 1;
                        npc = t ? x_target : x_pc_plus2;
                    end
                end else if (xop == 5'd5 || xop == 5'd7) begin
                    nr = 1;
                    npc = rt;
                end
            end
            if (nr) begin
                if (m_cnt < 65535) m_cnt++;
                rq.push_back('{cyc + 1, npc, 16'(m_cnt)});
            end
            m_redir = nr;
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [4:0] op);
        drive(0, 1, pc, op, 0, 0, 0, 0, 0, 0);
    endtask

    // Branch with the model's own prediction; skips the squash cycle if it mispredicts.
    task automatic xb(input logic [4:0] op, input logic [15:0] pc, input logic [2:0] fl);
        drive(0, 0, 0, 0, 1, pc, op, model_pred(pc, op), fl, 16'($urandom));
        if (m_redir) idle();
    endtask

    // Monitor: compares combinational outputs every cycle and redirect events as they appear.
    always @(negedge clk) begin
        comb_t c;
        rev_t  e;
        if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("p_taken", 32'(p_taken), 32'(c.p));
            chk("link_en", 32'(link_en), 32'(c.l));
        end
        if (redirect === 1'b1) begin
            if (rq.size() == 0) begin
                chk("unexpected_redirect", 32'(redirect), 32'(0));
            end else begin
                e = rq.pop_front();
                chk("redirect_cycle", 32'(cyc), 32'(e.cyc));
                chk("redirect_pc", 32'(redirect_pc), 32'(e.pc));
                chk("mispredict_cnt", 32'(mispredict_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [4:0] ops [10] = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd4, 5'd5, 5'd6, 5'd7, 5'd0, 5'd3};
        foreach (m_ctr[i]) m_ctr[i] = 1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        chk("reset_redirect", 32'(redirect), 0);
        chk("reset_redirect_pc", 32'(redirect_pc), 0);
        chk("reset_cnt", 32'(mispredict_cnt), 0);
        fetch(16'h0010, 5'd12);
        // BEQZ taken, predicted not-taken
        drive(0, 0, 0, 0, 1, 16'h0010, 5'd12, 0, 3'b001, 0);
        fetch(16'h0010, 5'd12);
        fetch(16'h0010, 5'd12);
        // BNEZ taken four times, then not taken
        for (int i = 0; i < 4; i++) xb(5'd13, 16'h0020, 3'b010);
        fetch(16'h0020, 5'd13);
        xb(5'd13, 16'h0020, 3'b001);
        fetch(16'h0020, 5'd13);
        // JALR then J
        drive(0, 0, 0, 0, 1, 16'h0040, 5'd7, 0, 0, 16'h1234);
        idle();
        drive(0, 1, 16'h0044, 5'd4, 1, 16'h0044, 5'd4, 1, 0, 0);
        idle();
        // mispredicted BLTZ, then a mispredicting BGEZ in the squash cycle
        drive(0, 0, 0, 0, 1, 16'h0030, 5'd14, 1, 3'b001, 0);
        drive(0, 0, 0, 0, 1, 16'h0030, 5'd15, 0, 3'b100, 0);
        idle();
        fetch(16'h0030, 5'd14);
        fetch(16'h0030, 5'd15);
        // saturating count
        idle();
        force dut.cnt_q = 16'hFFFF;
        m_cnt = 65535;
        idle();
        release dut.cnt_q;
        drive(0, 0, 0, 0, 1, 16'h0050, 5'd5, 0, 0, 16'h0abc);
        idle();
        @(negedge clk);
        chk("cnt_saturated", 32'(mispredict_cnt), 32'hFFFF);
        // reset during a redirect cycle
        drive(0, 0, 0, 0, 1, 16'h0050, 5'd5, 0, 0, 16'h0def);
        drive(1, 0, 0, 0, 1, 16'h0050, 5'd5, 0, 0, 16'h0111);
        fetch(16'h0010, 5'd12);
        @(negedge clk);
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_redirect_pc", 32'(redirect_pc), 0);
        chk("rst_cnt", 32'(mispredict_cnt), 0);
        // randomized traffic over a few aliasing PCs
        for (int n = 0; n < 600; n++) begin
            logic [15:0] fpc, xpc;
            logic [4:0]  fop, xop;
            bit          xp;
            fpc = 16'(($urandom_range(0, 7) << 1) | ($urandom_range(0, 1) << 5));
            xpc = 16'(($urandom_range(0, 7) << 1) | ($urandom_range(0, 1) << 5));
            fop = ops[$urandom_range(0, 9)];
            xop = ops[$urandom_range(0, 9)];
            xp  = ($urandom_range(0, 9) < 7) ? model_pred(xpc, xop) : 1'($urandom);
            drive($urandom_range(0, 99) == 0, 1'($urandom), fpc, fop, 1'($urandom_range(0, 3) != 0),
                  xpc, xop, xp, 3'($urandom), 16'($urandom));
        end
        idle();
        idle();
        @(negedge clk);
        chk("pending_redirects", 32'(rq.size()), 0);
        chk("final_cnt", 32'(mispredict_cnt), 32'(m_cnt));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
